// File: rtl/board_judge.sv
`default_nettype none
// ============================================================================
// Module   : board_judge
// Brief    : 3x3 move-entry and win-detection stage feeding the game controller.
//            Optional draw detection is enabled by BOARD_JUDGE_DRAW_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module board_judge #(
    parameter int FIRST_PLAYER = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_valid,
    input  logic [3:0] move_cell,
    input  logic       clear,
    output logic       move_ack,
    output logic       move_err,
    output logic       turn,
    output logic [8:0] board_p1,
    output logic [8:0] board_p2,
    output logic       p1win,
    output logic       p2win,
    output logic       draw
);

    typedef enum logic [0:0] {
        PLAY   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic c_first = (FIRST_PLAYER != 0) ? 1'b1 : 1'b0;

    // Eight winning lines of a row-major 3x3 board.
    function automatic logic f_line(input logic [8:0] b);
        return (&b[2:0]) | (&b[5:3]) | (&b[8:6]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    state_t     r_state, w_state_nx;
    logic       r_turn, w_turn_nx;
    logic [8:0] r_p1, w_p1_nx;
    logic [8:0] r_p2, w_p2_nx;
    logic       r_ack, w_ack_nx;
    logic       r_err, w_err_nx;
    logic       r_p1win, w_p1win_nx;
    logic       r_p2win, w_p2win_nx;
    logic [8:0] w_cell_bit;
    logic       w_accept;
    logic       w_win;

    assign w_cell_bit = 9'd1 << move_cell;
    assign w_accept   = (r_state == PLAY) && (move_cell <= 4'd8) &&
                        (((r_p1 | r_p2) & w_cell_bit) == 9'd0);

`ifdef BOARD_JUDGE_DRAW_DETECT_EN
    logic r_draw, w_draw_nx;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_turn_nx  = r_turn;
        w_p1_nx    = r_p1;
        w_p2_nx    = r_p2;
        w_ack_nx   = 1'b0;
        w_err_nx   = 1'b0;
        w_p1win_nx = r_p1win;
        w_p2win_nx = r_p2win;
        w_win      = 1'b0;
`ifdef BOARD_JUDGE_DRAW_DETECT_EN
        w_draw_nx  = r_draw;
`endif
        if (clear) begin
            // Clear wins over a coincident move, which is silently dropped.
            w_state_nx = PLAY;
            w_turn_nx  = c_first;
            w_p1_nx    = 9'd0;
            w_p2_nx    = 9'd0;
            w_p1win_nx = 1'b0;
            w_p2win_nx = 1'b0;
`ifdef BOARD_JUDGE_DRAW_DETECT_EN
            w_draw_nx  = 1'b0;
`endif
        end else if (move_valid) begin
            if (w_accept) begin
                w_ack_nx  = 1'b1;
                w_turn_nx = ~r_turn;
                if (!r_turn) begin
                    w_p1_nx    = r_p1 | w_cell_bit;
                    w_win      = f_line(w_p1_nx);
                    w_p1win_nx = w_win;
                end else begin
                    w_p2_nx    = r_p2 | w_cell_bit;
                    w_win      = f_line(w_p2_nx);
                    w_p2win_nx = w_win;
                end
                if (w_win) begin
                    w_state_nx = LOCKED;
                end
`ifdef BOARD_JUDGE_DRAW_DETECT_EN
                if (!w_win && (&(w_p1_nx | w_p2_nx))) begin
                    w_draw_nx  = 1'b1;
                    w_state_nx = LOCKED;
                end
`endif
            end else begin
                w_err_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= PLAY;
            r_turn  <= c_first;
            r_p1    <= 9'd0;
            r_p2    <= 9'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_p1win <= 1'b0;
            r_p2win <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_turn  <= w_turn_nx;
            r_p1    <= w_p1_nx;
            r_p2    <= w_p2_nx;
            r_ack   <= w_ack_nx;
            r_err   <= w_err_nx;
            r_p1win <= w_p1win_nx;
            r_p2win <= w_p2win_nx;
        end
    end

`ifdef BOARD_JUDGE_DRAW_DETECT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_draw <= 1'b0;
        end else begin
            r_draw <= w_draw_nx;
        end
    end
    assign draw = r_draw;
`else
    assign draw = 1'b0;
`endif

    assign move_ack = r_ack;
    assign move_err = r_err;
    assign turn     = r_turn;
    assign board_p1 = r_p1;
    assign board_p2 = r_p2;
    assign p1win    = r_p1win;
    assign p2win    = r_p2win;

endmodule
`default_nettype wire

// File: tb/tb_board_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_judge
// Brief    : Directed self-checking bench for board_judge (FIRST_PLAYER = 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_judge;

    logic       clk;
    logic       reset;
    logic       move_valid;
    logic [3:0] move_cell;
    logic       clear;
    logic       move_ack;
    logic       move_err;
    logic       turn;
    logic [8:0] board_p1;
    logic [8:0] board_p2;
    logic       p1win;
    logic       p2win;
    logic       draw;

    int total = 0;
    int bad   = 0;

    board_judge #(.FIRST_PLAYER(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .move_valid (move_valid),
        .move_cell  (move_cell),
        .clear      (clear),
        .move_ack   (move_ack),
        .move_err   (move_err),
        .turn       (turn),
        .board_p1   (board_p1),
        .board_p2   (board_p2),
        .p1win      (p1win),
        .p2win      (p2win),
        .draw       (draw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: present inputs, let one rising edge sample them,
    // return at the next falling edge where the registered results are visible.
    task automatic step(input logic v, input logic [3:0] c, input logic clr);
        move_valid = v;
        move_cell  = c;
        clear      = clr;
        @(negedge clk);
        move_valid = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic mv_ok(input string tag, input logic [3:0] c);
        step(1'b1, c, 1'b0);
        chk(tag, {8'd0, move_ack}, 9'd1);
    endtask

    initial begin
        reset      = 1'b1;
        move_valid = 1'b0;
        move_cell  = 4'd0;
        clear      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_p1",   board_p1, 9'h000);
        chk("rst_p2",   board_p2, 9'h000);
        chk("rst_turn", {8'd0, turn}, 9'd0);
        chk("rst_wins", {7'd0, p1win, p2win}, 9'd0);
        chk("rst_ackerr", {7'd0, move_ack, move_err}, 9'd0);
        chk("rst_draw", {8'd0, draw}, 9'd0);
        reset = 1'b0;
        @(negedge clk);

        // Row win for player 1, moves presented on consecutive cycles.
        move_valid = 1'b1; move_cell = 4'd0; @(negedge clk);
        chk("row_m1_ack", {8'd0, move_ack}, 9'd1);
        chk("row_m1_turn", {8'd0, turn}, 9'd1);
        move_cell = 4'd3; @(negedge clk);
        chk("row_m2_ack", {8'd0, move_ack}, 9'd1);
        chk("row_m2_turn", {8'd0, turn}, 9'd0);
        move_cell = 4'd1; @(negedge clk);
        chk("row_m3_ack", {8'd0, move_ack}, 9'd1);
        move_cell = 4'd4; @(negedge clk);
        chk("row_m4_ack", {8'd0, move_ack}, 9'd1);
        chk("row_m4_nowin", {7'd0, p1win, p2win}, 9'd0);
        move_cell = 4'd2; @(negedge clk);
        move_valid = 1'b0;
        chk("row_m5_ack", {8'd0, move_ack}, 9'd1);
        chk("row_p1win", {8'd0, p1win}, 9'd1);
        chk("row_p2win", {8'd0, p2win}, 9'd0);
        chk("row_bp1", board_p1, 9'h007);
        chk("row_bp2", board_p2, 9'h018);
        step(1'b1, 4'd8, 1'b0);
        chk("locked_err", {8'd0, move_err}, 9'd1);
        chk("locked_ack", {8'd0, move_ack}, 9'd0);
        chk("locked_bp2", board_p2, 9'h018);
        chk("locked_turn", {8'd0, turn}, 9'd1);
        @(negedge clk);
        chk("win_hold", {8'd0, p1win}, 9'd1);
        chk("err_pulse", {8'd0, move_err}, 9'd0);

        // Clear colliding with a move after a win.
        step(1'b1, 4'd1, 1'b1);
        chk("clrwin_bp1", board_p1, 9'h000);
        chk("clrwin_bp2", board_p2, 9'h000);
        chk("clrwin_turn", {8'd0, turn}, 9'd0);
        chk("clrwin_ackerr", {7'd0, move_ack, move_err}, 9'd0);
        chk("clrwin_p1win", {8'd0, p1win}, 9'd0);

        // Occupied cell, back in PLAY.
        mv_ok("occ_m1", 4'd4);
        step(1'b1, 4'd4, 1'b0);
        chk("occ_err", {8'd0, move_err}, 9'd1);
        chk("occ_turn", {8'd0, turn}, 9'd1);
        chk("occ_bp2", board_p2, 9'h000);
        mv_ok("occ_m3", 4'd0);
        chk("occ_bp2b", board_p2, 9'h001);

        // Out-of-range cell indices.
        step(1'b1, 4'd9, 1'b0);
        chk("idx9_err", {8'd0, move_err}, 9'd1);
        chk("idx9_bp1", board_p1, 9'h010);
        step(1'b1, 4'd15, 1'b0);
        chk("idx15_err", {8'd0, move_err}, 9'd1);
        chk("idx15_turn", {8'd0, turn}, 9'd0);
        chk("idx15_bp2", board_p2, 9'h001);

        // Clear/move collision mid-game with only P1:0 on the board.
        step(1'b0, 4'd0, 1'b1);
        mv_ok("col_m1", 4'd0);
        step(1'b1, 4'd1, 1'b1);
        chk("col_bp1", board_p1, 9'h000);
        chk("col_bp2", board_p2, 9'h000);
        chk("col_turn", {8'd0, turn}, 9'd0);
        chk("col_ackerr", {7'd0, move_ack, move_err}, 9'd0);

        // Column win for player 2 (cells 1,4,7).
        mv_ok("p2w_m1", 4'd0);
        mv_ok("p2w_m2", 4'd1);
        mv_ok("p2w_m3", 4'd3);
        mv_ok("p2w_m4", 4'd4);
        mv_ok("p2w_m5", 4'd8);
        chk("p2w_none", {7'd0, p1win, p2win}, 9'd0);
        mv_ok("p2w_m6", 4'd7);
        chk("p2w_wins", {7'd0, p1win, p2win}, 9'd1);
        chk("p2w_bp2", board_p2, 9'h092);

        // Clear, then draw game.
        step(1'b0, 4'd0, 1'b1);
        mv_ok("dr_m1", 4'd0);
        mv_ok("dr_m2", 4'd1);
        mv_ok("dr_m3", 4'd2);
        mv_ok("dr_m4", 4'd4);
        mv_ok("dr_m5", 4'd3);
        mv_ok("dr_m6", 4'd5);
        mv_ok("dr_m7", 4'd7);
        mv_ok("dr_m8", 4'd6);
        mv_ok("dr_m9", 4'd8);
        chk("dr_bp1", board_p1, 9'h18D);
        chk("dr_bp2", board_p2, 9'h072);
        chk("dr_wins", {7'd0, p1win, p2win}, 9'd0);
`ifdef BOARD_JUDGE_DRAW_DETECT_EN
        chk("dr_draw", {8'd0, draw}, 9'd1);
`else
        chk("dr_draw", {8'd0, draw}, 9'd0);
`endif
        step(1'b1, 4'd4, 1'b0);
        chk("dr_after_err", {8'd0, move_err}, 9'd1);
        step(1'b0, 4'd0, 1'b1);
        chk("dr_clr_draw", {8'd0, draw}, 9'd0);
        chk("dr_clr_bp1", board_p1, 9'h000);

        // Async reset between clock edges, mid-game.
        mv_ok("ar_m1", 4'd0);
        mv_ok("ar_m2", 4'd4);
        chk("ar_pre_bp2", board_p2, 9'h010);
        #2 reset = 1'b1;
        #1;
        chk("ar_bp1", board_p1, 9'h000);
        chk("ar_bp2", board_p2, 9'h000);
        chk("ar_turn", {8'd0, turn}, 9'd0);
        chk("ar_flags", {6'd0, p1win, p2win, draw}, 9'd0);
        @(negedge clk);
        reset = 1'b0;
        mv_ok("ar_after", 4'd4);
        chk("ar_after_bp1", board_p1, 9'h010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
